store_unit: RTL and testbench

Store-side companion to the load extender: accepts one store per request from the MEM stage and drives a word-organised data memory write port. It performs byte-lane steering for sb/sh/sw, generates byte enables, and holds each write until the memory acknowledges it. A small FSM splits stores that cross a word boundary into two aligned writes.

---
 rtl/store_unit.sv | 199 +++++++++++++++++++
 tb/tb_store_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store lane steering and write-port sequencer for sb/sh/sw
// Optional STORE_SPLIT_EN: cross-word stores become two aligned writes instead of being rejected.
module store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        StoreTypeM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       WriteDataM,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1
`ifdef STORE_SPLIT_EN
        ,
        WR1  = 2'd2
`endif
    } state_t;

    state_t            r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic              r_misaligned;

    state_t            w_nxt_state;
    logic              w_nxt_we;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [3:0]        w_nxt_be;
    logic [31:0]       w_nxt_wdata;
    logic              w_nxt_done;
    logic              w_nxt_mis;

    logic [3:0]        w_mask;
    logic              w_legal;
    logic [7:0]        w_be8;
    logic              w_cross;
    logic [31:0]       w_wlo;
    logic [ADDR_W-1:0] w_base;

`ifdef STORE_SPLIT_EN
    logic [3:0]        r_hi_be;
    logic [31:0]       r_hi_wdata;
    logic [3:0]        w_nxt_hi_be;
    logic [31:0]       w_nxt_hi_wdata;
    logic [63:0]       w_d64;
    logic [31:0]       w_whi;

    assign w_d64 = {32'h0000_0000, WriteDataM} << {addrM[1:0], 3'b000};
    assign w_wlo = w_d64[31:0];
    assign w_whi = w_d64[63:32];
`else
    assign w_wlo = WriteDataM << {addrM[1:0], 3'b000};
`endif

    always_comb begin
        w_mask  = 4'b0000;
        w_legal = 1'b1;
        case (StoreTypeM)
            3'b000:  w_mask = 4'b0001;
            3'b001:  w_mask = 4'b0011;
            3'b010:  w_mask = 4'b1111;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_be8   = {4'b0000, w_mask} << addrM[1:0];
    assign w_cross = |w_be8[7:4];
    assign w_base  = {addrM[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_we    = r_mem_we;
        w_nxt_addr  = r_mem_addr;
        w_nxt_be    = r_mem_be;
        w_nxt_wdata = r_mem_wdata;
        w_nxt_done  = 1'b0;
        w_nxt_mis   = 1'b0;
`ifdef STORE_SPLIT_EN
        w_nxt_hi_be    = r_hi_be;
        w_nxt_hi_wdata = r_hi_wdata;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (!w_legal) begin
                        w_nxt_done = 1'b1;
`ifndef STORE_SPLIT_EN
                    end else if (w_cross) begin
                        w_nxt_done = 1'b1;
                        w_nxt_mis  = 1'b1;
`endif
                    end else begin
                        w_nxt_state = WR0;
                        w_nxt_we    = 1'b1;
                        w_nxt_addr  = w_base;
                        w_nxt_be    = w_be8[3:0];
                        w_nxt_wdata = w_wlo;
`ifdef STORE_SPLIT_EN
                        w_nxt_hi_be    = w_be8[7:4];
                        w_nxt_hi_wdata = w_whi;
`endif
                    end
                end
            end
            WR0: begin
                if (mem_ack) begin
`ifdef STORE_SPLIT_EN
                    if (|r_hi_be) begin
                        // second half loads on the ack edge so mem_we never drops between halves
                        w_nxt_state = WR1;
                        w_nxt_addr  = r_mem_addr + ADDR_W'(4);
                        w_nxt_be    = r_hi_be;
                        w_nxt_wdata = r_hi_wdata;
                    end else begin
`endif
                        w_nxt_state = IDLE;
                        w_nxt_we    = 1'b0;
                        w_nxt_addr  = '0;
                        w_nxt_be    = 4'b0000;
                        w_nxt_wdata = 32'h0;
                        w_nxt_done  = 1'b1;
`ifdef STORE_SPLIT_EN
                    end
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            WR1: begin
                if (mem_ack) begin
                    w_nxt_state = IDLE;
                    w_nxt_we    = 1'b0;
                    w_nxt_addr  = '0;
                    w_nxt_be    = 4'b0000;
                    w_nxt_wdata = 32'h0;
                    w_nxt_done  = 1'b1;
                end
            end
`endif
            default: begin
                w_nxt_state = IDLE;
                w_nxt_we    = 1'b0;
                w_nxt_addr  = '0;
                w_nxt_be    = 4'b0000;
                w_nxt_wdata = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
`ifdef STORE_SPLIT_EN
            r_hi_be      <= 4'b0000;
            r_hi_wdata   <= 32'h0;
`endif
        end else begin
            r_state      <= w_nxt_state;
            r_mem_we     <= w_nxt_we;
            r_mem_addr   <= w_nxt_addr;
            r_mem_be     <= w_nxt_be;
            r_mem_wdata  <= w_nxt_wdata;
            r_done       <= w_nxt_done;
            r_misaligned <= w_nxt_mis;
`ifdef STORE_SPLIT_EN
            r_hi_be      <= w_nxt_hi_be;
            r_hi_wdata   <= w_nxt_hi_wdata;
`endif
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign done       = r_done;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit, follows STORE_SPLIT_EN of the build
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  StoreTypeM;
    logic [31:0] addrM;
    logic [31:0] WriteDataM;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        done;
    logic        misaligned;

    always #5 clk = ~clk;

    store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .StoreTypeM (StoreTypeM),
        .addrM      (addrM),
        .WriteDataM (WriteDataM),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .misaligned (misaligned)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_t;

    wr_t  wq[$];
    logic dq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.addr  = a;
        w.be    = be;
        w.wdata = d;
        wq.push_back(w);
    endtask

    task automatic push_model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  m;
        logic [7:0]  be8;
        logic [63:0] d64;
        logic [31:0] base;
        case (t)
            3'b000:  m = 4'b0001;
            3'b001:  m = 4'b0011;
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        be8  = {4'b0000, m} << a[1:0];
        d64  = {32'h0, d} << (8 * a[1:0]);
        base = {a[31:2], 2'b00};
        if (m == 4'b0000) begin
            dq.push_back(1'b0);
        end else if (be8[7:4] != 4'b0000) begin
`ifdef STORE_SPLIT_EN
            push_wr(base, be8[3:0], d64[31:0]);
            push_wr(base + 32'd4, be8[7:4], d64[63:32]);
            dq.push_back(1'b0);
`else
            dq.push_back(1'b1);
`endif
        end else begin
            push_wr(base, be8[3:0], d64[31:0]);
            dq.push_back(1'b0);
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the done cycle.
    task automatic do_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                            input int waits);
        int          halves;
        logic [31:0] sa;
        logic [35:0] sbd;
        wr_t         w;
        halves     = 0;
        req_valid  = 1'b1;
        StoreTypeM = t;
        addrM      = a;
        WriteDataM = d;
        check_eq("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid  = 1'b0;
        while (mem_we && halves < 3) begin
            sa  = mem_addr;
            sbd = {mem_be, mem_wdata};
            for (int i = 0; i < waits; i++) begin
                check_eq("done_during_wait", done, 0);
                @(negedge clk);
                check_eq("stable_we", mem_we, 1);
                check_eq("stable_addr", mem_addr, sa);
                check_eq("stable_be_wdata", {mem_be, mem_wdata}, sbd);
            end
            mem_ack = 1'b1;
            if (wq.size() == 0) begin
                check_eq("unexpected_write", 1, 0);
            end else begin
                w = wq.pop_front();
                check_eq("wr_addr", mem_addr, w.addr);
                check_eq("wr_be", mem_be, w.be);
                check_eq("wr_wdata", mem_wdata, w.wdata);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            halves++;
        end
        check_eq("done", done, 1);
        check_eq("ready_in_done", req_ready, 1);
        check_eq("we_low_in_done", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
        if (dq.size() == 0) check_eq("unexpected_done", 1, 0);
        else check_eq("misaligned", misaligned, dq.pop_front());
        check_eq("writes_missing", wq.size(), 0);
        wq.delete();
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        reset      = 1'b1;
        req_valid  = 1'b0;
        StoreTypeM = 3'b000;
        addrM      = 32'h0;
        WriteDataM = 32'h0;
        mem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_be_wdata", {mem_be, mem_wdata}, 0);
        check_eq("rst_done_mis", {done, misaligned}, 0);
        check_eq("rst_ready", req_ready, 1);

        push_wr(32'h0000_1000, 4'b0100, 32'h00A5_0000); dq.push_back(1'b0);
        do_store(3'b000, 32'h0000_1002, 32'h0000_00A5, 0);

        push_wr(32'h0000_2000, 4'b1100, 32'h1234_0000); dq.push_back(1'b0);
        do_store(3'b001, 32'h0000_2002, 32'h0000_1234, 3);

`ifdef STORE_SPLIT_EN
        push_wr(32'h0000_3000, 4'b1110, 32'hBBCC_DD00);
        push_wr(32'h0000_3004, 4'b0001, 32'h0000_00AA); dq.push_back(1'b0);
        do_store(3'b010, 32'h0000_3001, 32'hAABB_CCDD, 1);
        push_wr(32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000);
        push_wr(32'h0000_0000, 4'b0011, 32'h0000_AABB); dq.push_back(1'b0);
        do_store(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0);
        push_wr(32'h0000_5000, 4'b1000, 32'hEF00_0000);
        push_wr(32'h0000_5004, 4'b0001, 32'h0000_00BE); dq.push_back(1'b0);
        do_store(3'b001, 32'h0000_5003, 32'h0000_BEEF, 2);
`else
        dq.push_back(1'b1);
        do_store(3'b010, 32'h0000_3001, 32'hAABB_CCDD, 0);
        dq.push_back(1'b1);
        do_store(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0);
        dq.push_back(1'b1);
        do_store(3'b001, 32'h0000_5003, 32'h0000_BEEF, 0);
`endif

        push_wr(32'h0000_4000, 4'b0110, 32'h00BE_EF00); dq.push_back(1'b0);
        do_store(3'b001, 32'h0000_4001, 32'h0000_BEEF, 0);

        dq.push_back(1'b0);
        do_store(3'b011, 32'h0000_7000, 32'h1111_2222, 0);

        push_wr(32'h0000_6000, 4'b1000, 32'h7F00_0000); dq.push_back(1'b0);
        do_store(3'b000, 32'h0000_6003, 32'h0000_007F, 1);

        for (int n = 0; n < 24; n++) begin
            t = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a = $urandom;
            d = $urandom;
            if (t == 3'b000) d = d & 32'h0000_00FF;
            else if (t == 3'b001) d = d & 32'h0000_FFFF;
            push_model(t, a, d);
            do_store(t, a, d, $urandom_range(0, 2));
        end

        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("idle_ack_we", mem_we, 0);
        check_eq("idle_ack_done", done, 0);

        req_valid  = 1'b1;
        StoreTypeM = 3'b010;
`ifdef STORE_SPLIT_EN
        addrM      = 32'h0000_3001;
`else
        addrM      = 32'h0000_3000;
`endif
        WriteDataM = 32'hAABB_CCDD;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("pre_rst_we", mem_we, 1);
`ifdef STORE_SPLIT_EN
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("wr1_we", mem_we, 1);
        check_eq("wr1_addr", mem_addr, 32'h0000_3004);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_we", mem_we, 0);
        check_eq("midrst_ready", req_ready, 1);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_addr", mem_addr, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("postrst_ack_we", mem_we, 0);
        check_eq("postrst_ack_done", done, 0);
        @(negedge clk);
        check_eq("postrst_done_late", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
